memory_responder: RTL and testbench

Word-addressed data memory that answers the processor's memory bus: it samples MEM_AddressLine, MEM_WriteLine, MEM_WriteSignal and MEM_ReadSignal, and returns MEM_ReadLine. Every access ends with a single-cycle MEM_Ready pulse after a programmable number of wait states. The block sits between the datapath's memory port and on-chip storage, so the control unit can stall on slow memory. Out-of-range addresses are reported on MEM_Fault and never modify storage.

---
 rtl/memory_responder_if.sv | 30 +++
 rtl/memory_responder.sv | 154 +++++++++++++++
 tb/tb_memory_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder_if
// Description : Processor memory-bus bundle between a requester (datapath
//               memory port) and the memory_responder storage block.
//               master : drives address, write data and the request strobes.
//               slave  : returns read data, the completion pulse and the
//                        out-of-range flag.
// Revision    : 1.0  initial release
// ============================================================================
interface memory_responder_if;
    logic [15:0] MEM_AddressLine;   // word address of the access
    logic [15:0] MEM_WriteLine;     // write data
    logic        MEM_WriteSignal;   // write request, level-sensitive
    logic        MEM_ReadSignal;    // read request, level-sensitive
    logic [15:0] MEM_ReadLine;      // registered read data
    logic        MEM_Ready;         // one-cycle completion pulse
    logic        MEM_Fault;         // address out of range, valid with MEM_Ready

    modport master (
        output MEM_AddressLine, MEM_WriteLine, MEM_WriteSignal, MEM_ReadSignal,
        input  MEM_ReadLine, MEM_Ready, MEM_Fault
    );

    modport slave (
        input  MEM_AddressLine, MEM_WriteLine, MEM_WriteSignal, MEM_ReadSignal,
        output MEM_ReadLine, MEM_Ready, MEM_Fault
    );
endinterface
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Word-addressed 16-bit data memory answering the processor
//               memory bus with a programmable number of wait states.
//               Every access ends with a single-cycle MEM_Ready pulse;
//               addresses beyond the implemented depth raise MEM_Fault and
//               never touch storage.
// Ports       : ClockInput - system clock, rising edge
//               ResetN     - asynchronous active-low reset
//               bus        - memory_responder_if.slave (address, write data,
//                            read/write strobes in; read data, ready, fault out)
// Parameters  : ADDR_BITS   - implemented address width (depth 2^ADDR_BITS)
//               WAIT_STATES - extra cycles before MEM_Ready, 0..15
// Revision    : 1.0  initial release
// ============================================================================
module memory_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  wire logic         ClockInput,
    input  wire logic         ResetN,
    memory_responder_if.slave bus
);

    localparam int         c_depth      = 1 << ADDR_BITS;
    localparam logic [3:0] c_waitStates = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_isWrite;
    logic [15:0] r_readLine;
    logic        r_ready;
    logic        r_fault;
    logic [15:0] r_mem [c_depth];

    logic                 w_request;
    logic                 w_commit;
    logic [15:0]          w_commitAddr;
    logic [15:0]          w_commitData;
    logic                 w_commitWrite;
    logic                 w_inRange;
    logic [ADDR_BITS-1:0] w_memIdx;

    assign w_request = bus.MEM_WriteSignal | bus.MEM_ReadSignal;

    // The commit happens on the edge that enters DONE. With zero wait states
    // that edge is the sampling edge itself, so the live bus values are used
    // instead of the (not yet loaded) latched copies.
    always_comb begin
        w_commit      = 1'b0;
        w_commitAddr  = r_addr;
        w_commitData  = r_data;
        w_commitWrite = r_isWrite;
        case (r_state)
            ST_IDLE: begin
                if (w_request && (c_waitStates == 4'd0)) begin
                    w_commit      = 1'b1;
                    w_commitAddr  = bus.MEM_AddressLine;
                    w_commitData  = bus.MEM_WriteLine;
                    w_commitWrite = bus.MEM_WriteSignal;
                end
            end
            ST_WAIT: begin
                if (r_count <= 4'd1) begin
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    assign w_inRange = ((w_commitAddr >> ADDR_BITS) == 16'd0);
    assign w_memIdx  = w_commitAddr[ADDR_BITS-1:0];

    // Control FSM with registered outputs.
    always_ff @(posedge ClockInput or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= 16'h0000;
            r_data     <= 16'h0000;
            r_isWrite  <= 1'b0;
            r_readLine <= 16'h0000;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_addr    <= bus.MEM_AddressLine;
                        r_data    <= bus.MEM_WriteLine;
                        // A simultaneous read+write request is a write.
                        r_isWrite <= bus.MEM_WriteSignal;
                        if (c_waitStates == 4'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= c_waitStates;
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_commit) begin
                r_ready <= 1'b1;
                r_fault <= ~w_inRange;
                if (!w_inRange) begin
                    r_readLine <= 16'h0000;
                end else if (!w_commitWrite) begin
                    r_readLine <= r_mem[w_memIdx];
                end
            end
        end
    end

    // Storage is never reset; the ResetN term keeps a request that is held
    // through reset from writing on a zero-wait-state configuration.
    always_ff @(posedge ClockInput) begin
        if (w_commit && w_inRange && w_commitWrite && ResetN) begin
            r_mem[w_memIdx] <= w_commitData;
        end
    end

    assign bus.MEM_ReadLine = r_readLine;
    assign bus.MEM_Ready    = r_ready;
    assign bus.MEM_Fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Directed self-checking bench for memory_responder. Three
//               instances share clock and reset: WAIT_STATES = 0, 1 and 3,
//               all with ADDR_BITS = 8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_memory_responder;

    logic clk;
    logic rstN;
    int   nChecks;
    int   nFails;

    memory_responder_if ifW0 ();
    memory_responder_if ifW1 ();
    memory_responder_if ifW3 ();

    memory_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dutW0 (
        .ClockInput (clk),
        .ResetN     (rstN),
        .bus        (ifW0)
    );
    memory_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) dutW1 (
        .ClockInput (clk),
        .ResetN     (rstN),
        .bus        (ifW1)
    );
    memory_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) dutW3 (
        .ClockInput (clk),
        .ResetN     (rstN),
        .bus        (ifW3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveReq(input int which, input logic wr, input logic rd,
                            input logic [15:0] addr, input logic [15:0] data);
        case (which)
            0: begin
                ifW0.MEM_WriteSignal = wr; ifW0.MEM_ReadSignal = rd;
                ifW0.MEM_AddressLine = addr; ifW0.MEM_WriteLine = data;
            end
            1: begin
                ifW1.MEM_WriteSignal = wr; ifW1.MEM_ReadSignal = rd;
                ifW1.MEM_AddressLine = addr; ifW1.MEM_WriteLine = data;
            end
            default: begin
                ifW3.MEM_WriteSignal = wr; ifW3.MEM_ReadSignal = rd;
                ifW3.MEM_AddressLine = addr; ifW3.MEM_WriteLine = data;
            end
        endcase
    endtask

    task automatic setAddr(input int which, input logic [15:0] addr);
        case (which)
            0:       ifW0.MEM_AddressLine = addr;
            1:       ifW1.MEM_AddressLine = addr;
            default: ifW3.MEM_AddressLine = addr;
        endcase
    endtask

    function automatic logic getReady(input int which);
        case (which)
            0:       return ifW0.MEM_Ready;
            1:       return ifW1.MEM_Ready;
            default: return ifW3.MEM_Ready;
        endcase
    endfunction

    function automatic logic getFault(input int which);
        case (which)
            0:       return ifW0.MEM_Fault;
            1:       return ifW1.MEM_Fault;
            default: return ifW3.MEM_Fault;
        endcase
    endfunction

    function automatic logic [15:0] getRead(input int which);
        case (which)
            0:       return ifW0.MEM_ReadLine;
            1:       return ifW1.MEM_ReadLine;
            default: return ifW3.MEM_ReadLine;
        endcase
    endfunction

    // One transaction: request driven just after edge E, latency counted in
    // edges until MEM_Ready is seen, then the request is dropped and the
    // pulse is checked to last exactly one cycle.
    task automatic access(input int which, input logic wr, input logic rd,
                          input logic [15:0] addr, input logic [15:0] data,
                          input logic altEn, input logic [15:0] altAddr,
                          input int expLat, input logic expFault,
                          input logic chkRead, input logic [15:0] expRead,
                          input string tag);
        int   lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        driveReq(which, wr, rd, addr, data);
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (altEn && lat == 1) setAddr(which, altAddr);
            if (getReady(which)) seen = 1'b1;
        end
        driveReq(which, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check({tag, " latency"}, lat, expLat);
        if (seen) begin
            check({tag, " fault"}, {31'd0, getFault(which)}, {31'd0, expFault});
            if (chkRead) check({tag, " readLine"}, {16'd0, getRead(which)}, {16'd0, expRead});
        end
        @(posedge clk); #1;
        check({tag, " ready drop"}, {31'd0, getReady(which)}, 32'd0);
        check({tag, " fault drop"}, {31'd0, getFault(which)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nFails  = 0;
        rstN    = 1'b0;
        driveReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        driveReq(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        driveReq(3, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset state of every instance.
        #12;
        for (int w = 0; w < 4; w++) begin
            if (w != 2) begin
                check("reset ready", {31'd0, getReady(w)}, 32'd0);
                check("reset fault", {31'd0, getFault(w)}, 32'd0);
                check("reset readLine", {16'd0, getRead(w)}, 32'd0);
            end
        end
        rstN = 1'b1;

        // Reset aborts a write in flight (WAIT_STATES=3).
        access(3, 1'b1, 1'b0, 16'h0005, 16'h1111, 1'b0, 16'h0, 4, 1'b0, 1'b0, 16'h0, "w3 write 5");
        access(3, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h0, 4, 1'b0, 1'b1, 16'h1111, "w3 read 5");
        @(posedge clk); #1;
        driveReq(3, 1'b1, 1'b0, 16'h0005, 16'hBEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        check("abort ready", {31'd0, ifW3.MEM_Ready}, 32'd0);
        check("abort fault", {31'd0, ifW3.MEM_Fault}, 32'd0);
        check("abort readLine", {16'd0, ifW3.MEM_ReadLine}, 32'd0);
        driveReq(3, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        check("abort ready held", {31'd0, ifW3.MEM_Ready}, 32'd0);
        check("abort readLine held", {16'd0, ifW3.MEM_ReadLine}, 32'd0);
        rstN = 1'b1;
        access(3, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h0, 4, 1'b0, 1'b1, 16'h1111, "w3 read 5 after abort");

        // Write then read (WAIT_STATES=1).
        access(1, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 1'b0, 16'h0, 2, 1'b0, 1'b0, 16'h0, "w1 write 10");
        access(1, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0, 2, 1'b0, 1'b1, 16'hA5A5, "w1 read 10");

        // Zero wait states with a continuously held read.
        access(0, 1'b1, 1'b0, 16'h00FF, 16'h5A3C, 1'b0, 16'h0, 1, 1'b0, 1'b0, 16'h0, "w0 write ff");
        @(posedge clk); #1;
        driveReq(0, 1'b0, 1'b1, 16'h00FF, 16'h0000);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("w0 held ready", {31'd0, ifW0.MEM_Ready}, ((i % 2) == 1) ? 32'd1 : 32'd0);
            check("w0 held readLine", {16'd0, ifW0.MEM_ReadLine}, 32'h5A3C);
        end
        driveReq(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("w0 idle ready", {31'd0, ifW0.MEM_Ready}, 32'd0);

        // Out-of-range addresses (ADDR_BITS=8) never alias or load data.
        access(1, 1'b1, 1'b0, 16'h0000, 16'hCAFE, 1'b0, 16'h0, 2, 1'b0, 1'b0, 16'h0, "w1 write 0");
        access(1, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 2, 1'b1, 1'b1, 16'h0000, "w1 oor read a");
        access(1, 1'b1, 1'b0, 16'h0100, 16'h1234, 1'b0, 16'h0, 2, 1'b1, 1'b1, 16'h0000, "w1 oor write");
        access(1, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0, 2, 1'b1, 1'b1, 16'h0000, "w1 oor read b");
        access(1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0, 2, 1'b0, 1'b1, 16'hCAFE, "w1 read 0");

        // Simultaneous read+write behaves as a write.
        access(1, 1'b1, 1'b1, 16'h0003, 16'h7777, 1'b0, 16'h0, 2, 1'b0, 1'b1, 16'hCAFE, "w1 both");
        access(1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0, 2, 1'b0, 1'b1, 16'h7777, "w1 read 3");

        // Address change while the transaction is in flight (WAIT_STATES=3).
        access(3, 1'b1, 1'b0, 16'h0001, 16'h0101, 1'b0, 16'h0, 4, 1'b0, 1'b0, 16'h0, "w3 write 1");
        access(3, 1'b1, 1'b0, 16'h0002, 16'h0202, 1'b0, 16'h0, 4, 1'b0, 1'b0, 16'h0, "w3 write 2");
        access(3, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b1, 16'h0002, 4, 1'b0, 1'b1, 16'h0101, "w3 inflight");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
